// File: rtl/ncl_pkg.sv
// Shared NCL definitions: dual-rail digit encoding and the single-bit
// threshold-gate next-state rules used by the gate bank and its cells.
package ncl_pkg;

  typedef logic [1:0] ncl_digit_t;  // [1] = TRUE rail, [0] = FALSE rail

  localparam ncl_digit_t NCL_NULL = 2'b00;
  localparam ncl_digit_t NCL_D0   = 2'b01;
  localparam ncl_digit_t NCL_D1   = 2'b10;

  function automatic logic th12_f(input logic a, input logic b);
    return a | b;
  endfunction

  // C-element: set on both high, clear on both low, otherwise hold q
  function automatic logic th22_next(input logic a, input logic b, input logic q);
    return (a & b) | (q & (a | b));
  endfunction

  function automatic logic thnot_f(input logic a);
    return ~a;
  endfunction

endpackage

// File: rtl/ncl_th22_cell.sv
// Single-lane registered C-element (TH22). z_next exposes the value the
// register takes on the coming edge so the bank can build all_null from it.
module ncl_th22_cell
  import ncl_pkg::*;
#(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic init,
  input  logic a,
  input  logic b,
  output logic z,
  output logic z_next
);

  always_comb begin
    z_next = init ? RST : th22_next(a, b, z);
  end

  always_ff @(posedge clk) begin
    z <= z_next;
  end

endmodule

// File: rtl/ncl_threshold_gate_bank.sv
// Lane-parallel bank of clocked NCL threshold gates (TH12, TH22, THnotN)
// with a registered all_null flag coincident with the gate outputs.
module ncl_threshold_gate_bank
  import ncl_pkg::*;
#(
  parameter int unsigned W12      = 1,
  parameter int unsigned W22      = 1,
  parameter int unsigned WN       = 1,
  parameter logic        TH22_RST = 1'b0
) (
  input  logic           clk,
  input  logic           init,
  input  logic [W12-1:0] th12_a,
  input  logic [W12-1:0] th12_b,
  output logic [W12-1:0] th12_z,
  input  logic [W22-1:0] th22_a,
  input  logic [W22-1:0] th22_b,
  output logic [W22-1:0] th22_z,
  input  logic [WN-1:0]  thn_a,
  output logic [WN-1:0]  thn_z,
  output logic           all_null
);

  logic [W12-1:0] th12_next;
  logic [W22-1:0] th22_next_v;
  logic [WN-1:0]  thn_next;
  logic           all_null_next;

  always_comb begin
    th12_next = '0;
    if (!init) begin
      for (int unsigned i = 0; i < W12; i++) begin
        th12_next[i] = th12_f(th12_a[i], th12_b[i]);
      end
    end
  end

  always_comb begin
    thn_next = '0;
    if (!init) begin
      for (int unsigned i = 0; i < WN; i++) begin
        thn_next[i] = thnot_f(thn_a[i]);
      end
    end
  end

  for (genvar g = 0; g < W22; g++) begin : g_th22
    ncl_th22_cell #(
      .RST (TH22_RST)
    ) u_cell (
      .clk    (clk),
      .init   (init),
      .a      (th22_a[g]),
      .b      (th22_b[g]),
      .z      (th22_z[g]),
      .z_next (th22_next_v[g])
    );
  end

  // Built from next-state bits so the flag lands on the same edge as the outputs
  always_comb begin
    all_null_next = ~(|th12_next | |th22_next_v | |thn_next);
  end

  always_ff @(posedge clk) begin
    th12_z   <= th12_next;
    thn_z    <= thn_next;
    all_null <= all_null_next;
  end

endmodule

// File: tb/tb_ncl_threshold_gate_bank.sv
// Self-checking bench: directed steps plus random traffic against a
// count-based reference model of the NCL threshold gates.
module tb_ncl_threshold_gate_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       init;
  logic [3:0] th12_a, th12_b, th22_a, th22_b, thn_a;

  logic [3:0] z12_0, z22_0, zn_0;
  logic       an_0;
  logic [3:0] z12_1, z22_1, zn_1;
  logic       an_1;

  logic       r12z, r22z, rnz, ran, rb;
  bit         ring_sel;
  assign rb = ring_sel ? rnz : 1'b1;

  ncl_threshold_gate_bank #(.W12(4), .W22(4), .WN(4), .TH22_RST(1'b0)) u0 (
    .clk(clk), .init(init),
    .th12_a(th12_a), .th12_b(th12_b), .th12_z(z12_0),
    .th22_a(th22_a), .th22_b(th22_b), .th22_z(z22_0),
    .thn_a(thn_a), .thn_z(zn_0), .all_null(an_0)
  );

  ncl_threshold_gate_bank #(.W12(4), .W22(4), .WN(4), .TH22_RST(1'b1)) u1 (
    .clk(clk), .init(init),
    .th12_a(th12_a), .th12_b(th12_b), .th12_z(z12_1),
    .th22_a(th22_a), .th22_b(th22_b), .th22_z(z22_1),
    .thn_a(thn_a), .thn_z(zn_1), .all_null(an_1)
  );

  // Ring: THnotN output drives TH22 a, TH22 output drives THnotN input
  ncl_threshold_gate_bank #(.W12(1), .W22(1), .WN(1), .TH22_RST(1'b0)) u2 (
    .clk(clk), .init(init),
    .th12_a(1'b0), .th12_b(1'b0), .th12_z(r12z),
    .th22_a(rnz), .th22_b(rb), .th22_z(r22z),
    .thn_a(r22z), .thn_z(rnz), .all_null(ran)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit m12[4], m22a[4], m22b[4], mn[4];
  bit man0, man1, mr22, mrn, mran;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pack(input bit v[4]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  // C-element by count of asserted inputs: 2 -> DATA, 0 -> NULL, 1 -> keep
  function automatic bit c_elem(input int ones, input bit q);
    if (ones == 2) return 1'b1;
    if (ones == 0) return 1'b0;
    return q;
  endfunction

  task automatic tick();
    bit n12[4], n22a[4], n22b[4], nn[4];
    bit nr22, nrn;
    int c, ones0, ones1, ra, rbm;
    for (int i = 0; i < 4; i++) begin
      if (init) begin
        n12[i] = 0; nn[i] = 0; n22a[i] = 0; n22b[i] = 1;
      end else begin
        n12[i]  = (int'(th12_a[i]) + int'(th12_b[i])) >= 1;
        nn[i]   = (thn_a[i] == 1'b0);
        c       = int'(th22_a[i]) + int'(th22_b[i]);
        n22a[i] = c_elem(c, m22a[i]);
        n22b[i] = c_elem(c, m22b[i]);
      end
    end
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 4; i++) begin
      ones0 += int'(n12[i]) + int'(n22a[i]) + int'(nn[i]);
      ones1 += int'(n12[i]) + int'(n22b[i]) + int'(nn[i]);
    end
    ra  = int'(mrn);
    rbm = ring_sel ? int'(mrn) : 1;
    nr22 = init ? 1'b0 : c_elem(ra + rbm, mr22);
    nrn  = init ? 1'b0 : !mr22;
    for (int i = 0; i < 4; i++) begin
      m12[i] = n12[i]; m22a[i] = n22a[i]; m22b[i] = n22b[i]; mn[i] = nn[i];
    end
    man0 = (ones0 == 0);
    man1 = (ones1 == 0);
    mr22 = nr22;
    mrn  = nrn;
    mran = (int'(nr22) + int'(nrn)) == 0;
    @(posedge clk);
    #1;
    check("u0.th12_z", z12_0, pack(m12));
    check("u0.th22_z", z22_0, pack(m22a));
    check("u0.thn_z", zn_0, pack(mn));
    check("u0.all_null", {3'b0, an_0}, {3'b0, man0});
    check("u1.th12_z", z12_1, pack(m12));
    check("u1.th22_z", z22_1, pack(m22b));
    check("u1.thn_z", zn_1, pack(mn));
    check("u1.all_null", {3'b0, an_1}, {3'b0, man1});
    check("ring.th12_z", {3'b0, r12z}, 4'h0);
    check("ring.th22_z", {3'b0, r22z}, {3'b0, mr22});
    check("ring.thn_z", {3'b0, rnz}, {3'b0, mrn});
    check("ring.all_null", {3'b0, ran}, {3'b0, mran});
  endtask

  task automatic rand_inputs();
    th12_a = 4'($urandom); th12_b = 4'($urandom);
    th22_a = 4'($urandom); th22_b = 4'($urandom);
    thn_a  = 4'($urandom);
  endtask

  initial begin
    bit exp12[4];
    logic [1:0] seq22[6];
    bit exp22[6];
    bit ring_zn[8], ring_z22[8];
    logic [1:0] ab;

    ring_sel = 1'b0;
    init = 1'b1;

    // Reset edges with random inputs
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tick();
      check("rst.th12_z", z12_0, 4'h0);
      check("rst.th22_z", z22_0, 4'h0);
      check("rst.thn_z", zn_0, 4'h0);
      check("rst.all_null", {3'b0, an_0}, 4'h1);
      check("rst1.th22_z", z22_1, 4'hF);
      check("rst1.all_null", {3'b0, an_1}, 4'h0);
    end

    init = 1'b0;
    th12_a = '0; th12_b = '0; th22_a = '0; th22_b = '0; thn_a = 4'b0101;
    tick();
    check("release.thn_z", zn_0, 4'b1010);

    exp12[0] = 0; exp12[1] = 1; exp12[2] = 1; exp12[3] = 1;
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      th12_a[0] = ab[1];
      th12_b[0] = ab[0];
      tick();
      check("th12.lane0", {3'b0, z12_0[0]}, {3'b0, exp12[k]});
    end

    seq22[0] = 2'b00; seq22[1] = 2'b10; seq22[2] = 2'b11;
    seq22[3] = 2'b01; seq22[4] = 2'b00; seq22[5] = 2'b01;
    exp22[0] = 0; exp22[1] = 0; exp22[2] = 1;
    exp22[3] = 1; exp22[4] = 0; exp22[5] = 0;
    for (int k = 0; k < 6; k++) begin
      ab = seq22[k];
      th22_a[0] = ab[1];
      th22_b[0] = ab[0];
      tick();
      check("th22.hyst", {3'b0, z22_0[0]}, {3'b0, exp22[k]});
    end

    // Reset overrides a held DATA value
    th22_a[0] = 1'b1; th22_b[0] = 1'b1;
    tick();
    check("ovr.set", {3'b0, z22_0[0]}, 4'h1);
    th22_b[0] = 1'b0;
    init = 1'b1;
    tick();
    check("ovr.rst0", {3'b0, z22_0[0]}, 4'h0);
    check("ovr.rst1", {3'b0, z22_1[0]}, 4'h1);
    check("ovr.null1", {3'b0, an_1}, 4'h0);
    init = 1'b0;
    tick();
    check("ovr.hold0", {3'b0, z22_0[0]}, 4'h0);
    check("ovr.hold1", {3'b0, z22_1[0]}, 4'h1);

    // all_null: THnotN inputs high keep its outputs at NULL
    th12_a = '0; th12_b = '0; th22_a = '0; th22_b = '0; thn_a = 4'hF;
    tick();
    tick();
    check("null.idle", {3'b0, an_0}, 4'h1);
    th22_a[2] = 1'b1;
    tick();
    check("null.half", {3'b0, an_0}, 4'h1);
    th22_b[2] = 1'b1;
    tick();
    check("null.data", {3'b0, an_0}, 4'h0);
    check("null.z22", {3'b0, z22_0[2]}, 4'h1);

    // Random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      init = ($urandom_range(15) == 0);
      tick();
    end

    // Ring with b following the THnotN output: period-4 oscillation
    ring_sel = 1'b1;
    init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    ring_zn[0] = 1; ring_zn[1] = 1; ring_zn[2] = 0; ring_zn[3] = 0;
    ring_zn[4] = 1; ring_zn[5] = 1; ring_zn[6] = 0; ring_zn[7] = 0;
    ring_z22[0] = 0; ring_z22[1] = 1; ring_z22[2] = 1; ring_z22[3] = 0;
    ring_z22[4] = 0; ring_z22[5] = 1; ring_z22[6] = 1; ring_z22[7] = 0;
    for (int k = 0; k < 8; k++) begin
      rand_inputs();
      tick();
      check("ring.osc_thn", {3'b0, rnz}, {3'b0, ring_zn[k]});
      check("ring.osc_th22", {3'b0, r22z}, {3'b0, ring_z22[k]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
